// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package mem_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Active-low SRAM strobe bundle.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } sram_ctl_t;

    localparam sram_ctl_t SRAM_CTL_IDLE = '1;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side MAR/MDR request/response bundle.
interface mem_responder_if;
    logic        Req;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        R;

    modport master (output Req, WE, ADDR, WDATA, input RDATA, R);
    modport slave  (input Req, WE, ADDR, WDATA, output RDATA, R);
endinterface

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high reset.
module register #(
    parameter int unsigned N = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [N-1:0] D_In,
    output logic [N-1:0] D_Out
);

    logic [N-1:0] data_q;

    // Capture D_In when Load is asserted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
        end else if (Load) begin
            data_q <= D_In;
        end
    end

    assign D_Out = data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: runs multi-cycle async SRAM accesses for the CPU and
// decodes a single memory-mapped I/O address (switches in, hex display out).
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_responder_if.slave     bus,
    input  logic [15:0]        Switches,
    output logic [15:0]        HEX_Data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    input  logic [15:0]        SRAM_DQ_IN,
    output logic [15:0]        SRAM_DQ_OUT,
    output logic               SRAM_DQ_OE
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

    mem_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            io_q, io_d;

    logic            rdata_ld, hex_ld;
    logic [15:0]     rdata_din, rdata;
    sram_ctl_t       ctl;

    // Sequencer and request-latch state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            io_q    <= io_d;
        end
    end

    // Next state: accept in IDLE, count down in ACCESS, one-cycle DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        io_d     = io_q;
        rdata_ld = 1'b0;
        hex_ld   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    we_d    = bus.WE;
                    io_d    = (bus.ADDR == IO_ADDR);
                    cnt_d   = CntLoad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last strobe cycle: capture read data / update display here.
                    rdata_ld = !we_q;
                    hex_ld   = we_q && io_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM strobes and DQ direction decoded from state and the latched request.
    always_comb begin
        ctl        = SRAM_CTL_IDLE;
        SRAM_DQ_OE = 1'b0;
        if (!io_q) begin
            if (state_q == ACCESS) begin
                ctl.ce_n = 1'b0;
                ctl.ub_n = 1'b0;
                ctl.lb_n = 1'b0;
                if (we_q) begin
                    ctl.we_n   = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                end else begin
                    ctl.oe_n = 1'b0;
                end
            end else if (state_q == DONE) begin
                // Write data held one cycle past the WE_N rising edge.
                ctl.ce_n   = 1'b0;
                ctl.ub_n   = 1'b0;
                ctl.lb_n   = 1'b0;
                SRAM_DQ_OE = we_q;
            end
        end
    end

    assign rdata_din = io_q ? Switches : SRAM_DQ_IN;

    register #(.N(16)) u_rdata_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (rdata_ld),
        .D_In  (rdata_din),
        .D_Out (rdata)
    );

    register #(.N(16)) u_hex_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (hex_ld),
        .D_In  (wdata_q),
        .D_Out (HEX_Data)
    );

    assign bus.RDATA   = rdata;
    assign bus.R       = (state_q == DONE);
    assign SRAM_ADDR   = {{(SRAM_AW - 16){1'b0}}, addr_q};
    assign SRAM_DQ_OUT = wdata_q;
    assign SRAM_CE_N   = ctl.ce_n;
    assign SRAM_OE_N   = ctl.oe_n;
    assign SRAM_WE_N   = ctl.we_n;
    assign SRAM_UB_N   = ctl.ub_n;
    assign SRAM_LB_N   = ctl.lb_n;

endmodule
